// File: rtl/sobel_window.sv
// 3x3 neighbourhood generator for the Sobel stage: two line buffers feed a
// 3x3 shift window; emits one window per accepted pixel once fully interior.
module sobel_window #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  input  logic          sof,
  output logic [7:0]    z0,
  output logic [7:0]    z1,
  output logic [7:0]    z2,
  output logic [7:0]    z3,
  output logic [7:0]    z4,
  output logic [7:0]    z5,
  output logic [7:0]    z6,
  output logic [7:0]    z7,
  output logic [7:0]    z8,
  output logic          win_valid,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          frame_done
);

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [XW-1:0] cur_c;
  logic [YW-1:0] cur_r;
  logic          last_col;
  logic          last_row;
  logic          interior;
  logic [7:0]    lb1_rd;
  logic [7:0]    lb2_rd;

  logic [7:0] lb1 [WIDTH];
  logic [7:0] lb2 [WIDTH];

  // sof forces the current pixel to (0,0) whatever the counters say
  always_comb begin
    cur_c    = sof ? '0 : col;
    cur_r    = sof ? '0 : row;
    last_col = (cur_c == XW'(WIDTH - 1));
    last_row = (cur_r == YW'(HEIGHT - 1));
    interior = (cur_c >= XW'(2)) && (cur_r >= YW'(2));
    lb1_rd   = lb1[cur_c];
    lb2_rd   = lb2[cur_c];
  end

  // Line buffers: read-before-write, row-1 cascades into row-2
  always_ff @(posedge clock) begin
    if (pix_valid) begin
      lb2[cur_c] <= lb1_rd;
      lb1[cur_c] <= pix_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      z0         <= '0;
      z1         <= '0;
      z2         <= '0;
      z3         <= '0;
      z4         <= '0;
      z5         <= '0;
      z6         <= '0;
      z7         <= '0;
      z8         <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : cur_r + YW'(1);
        end else begin
          col <= cur_c + XW'(1);
          row <= cur_r;
        end
        // Shift columns left; new right column comes from the line buffers
        z0 <= z1;
        z1 <= z2;
        z2 <= lb2_rd;
        z3 <= z4;
        z4 <= z5;
        z5 <= lb1_rd;
        z6 <= z7;
        z7 <= z8;
        z8 <= pix_in;
        if (interior) begin
          win_valid  <= 1'b1;
          win_x      <= cur_c - XW'(1);
          win_y      <= cur_r - YW'(1);
          frame_done <= last_col && last_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window.sv
// Scoreboard bench for sobel_window: frame scenarios from a table, plus
// hand sequences for async reset and the 3x3 border case.
module tb_sobel_window;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;

  typedef struct packed {
    logic [8:0][7:0] z;
    logic [2:0]      x;
    logic [2:0]      y;
    logic            fd;
  } win_t;

  typedef struct {
    int toggle;
    int abort;
    int frames;
    int exp_pulses;
    int exp_fd;
  } scen_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic       win_valid, frame_done;
  logic [2:0] win_x, win_y;

  logic [7:0] b_pix = '0;
  logic       b_valid = 1'b0;
  logic       b_sof = 1'b0;
  logic [7:0] bz0, bz1, bz2, bz3, bz4, bz5, bz6, bz7, bz8;
  logic       b_win_valid, b_frame_done;
  logic [1:0] b_win_x, b_win_y;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_fd = 0;
  int b_pulse = 0;
  int b_x = 0;
  int b_y = 0;
  int b_fd = 0;
  int br = 0;
  int bc = 0;

  logic [7:0] img [H][W];
  win_t       exp_q[$];
  win_t       log_q[$];
  scen_t      tbl[4];

  always #5 clock = ~clock;

  sobel_window #(.WIDTH(W), .HEIGHT(H), .XW(3), .YW(3)) dut (
    .clock(clock), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .sof(sof), .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6),
    .z7(z7), .z8(z8), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done)
  );

  sobel_window #(.WIDTH(3), .HEIGHT(3), .XW(2), .YW(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .pix_in(b_pix), .pix_valid(b_valid),
    .sof(b_sof), .z0(bz0), .z1(bz1), .z2(bz2), .z3(bz3), .z4(bz4), .z5(bz5),
    .z6(bz6), .z7(bz7), .z8(bz8), .win_valid(b_win_valid), .win_x(b_win_x),
    .win_y(b_win_y), .frame_done(b_frame_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every window pulse pops the oldest expectation
  always @(negedge clock) begin
    win_t o;
    win_t e;
    if (win_valid) begin
      o.z  = {z8, z7, z6, z5, z4, z3, z2, z1, z0};
      o.x  = win_x;
      o.y  = win_y;
      o.fd = frame_done;
      n_pulse++;
      if (frame_done) n_fd++;
      log_q.push_back(o);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL window: unexpected pulse x=%0d y=%0d", win_x, win_y);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL window: got z=%h x=%0d y=%0d fd=%0b, want z=%h x=%0d y=%0d fd=%0b",
                   o.z, o.x, o.y, o.fd, e.z, e.x, e.y, e.fd);
        end
      end
    end
    if (b_win_valid) begin
      b_pulse++;
      b_x  = int'(b_win_x);
      b_y  = int'(b_win_y);
      b_fd = int'(b_frame_done);
    end
  end

  task automatic send(input logic [7:0] p, input logic s);
    win_t e;
    if (s) begin
      br = 0;
      bc = 0;
    end
    img[br][bc] = p;
    if (br >= 2 && bc >= 2) begin
      for (int k = 0; k < 9; k++) e.z[k] = img[br - 2 + k / 3][bc - 2 + k % 3];
      e.x  = 3'(bc - 1);
      e.y  = 3'(br - 1);
      e.fd = (br == H - 1) && (bc == W - 1);
      exp_q.push_back(e);
    end
    pix_in    = p;
    sof       = s;
    pix_valid = 1'b1;
    @(posedge clock);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    if (bc == W - 1) begin
      bc = 0;
      br = (br == H - 1) ? 0 : br + 1;
    end else begin
      bc = bc + 1;
    end
  endtask

  task automatic idle();
    logic [7:0] hz4;
    logic [2:0] hx;
    hz4 = z4;
    hx  = win_x;
    pix_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_win_valid", int'(win_valid), 0);
    chk("idle_hold_z4", int'(z4), int'(hz4));
    chk("idle_hold_x", int'(win_x), int'(hx));
  endtask

  // Ramp frame 16*row+col+off; stops before (stop_r, stop_c) if inside the frame
  task automatic send_frame(input logic [7:0] off, input int toggle,
                            input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        send(8'(16 * r + c) + off, (r == 0) && (c == 0));
        if (toggle != 0) idle();
      end
  endtask

  task automatic clear_logs();
    n_pulse = 0;
    n_fd    = 0;
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{0, 0, 1, 24, 1};
    tbl[1] = '{1, 0, 1, 24, 1};
    tbl[2] = '{0, 1, 1, 31, 1};
    tbl[3] = '{0, 0, 2, 48, 2};

    #2;
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_z4", int'(z4), 0);
    chk("rst_x", int'(win_x), 0);
    #10;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 4; i++) begin
      clear_logs();
      if (tbl[i].abort != 0) send_frame(8'h00, 0, 3, 3);
      for (int f = 0; f < tbl[i].frames; f++)
        send_frame((tbl[i].abort != 0 || f == 1) ? 8'h80 : 8'h00, tbl[i].toggle, H, W);
      repeat (3) @(posedge clock);
      #1;
      chk($sformatf("scen%0d_pulses", i), n_pulse, tbl[i].exp_pulses);
      chk($sformatf("scen%0d_frame_done", i), n_fd, tbl[i].exp_fd);
      chk($sformatf("scen%0d_drain", i), exp_q.size(), 0);
      if (i == 0 && log_q.size() == 24) begin
        chk("first_z", int'(log_q[0].z[0]), 'h00);
        chk("first_z4", int'(log_q[0].z[4]), 'h11);
        chk("first_z8", int'(log_q[0].z[8]), 'h22);
        chk("first_xy", int'({log_q[0].x, log_q[0].y}), int'({3'd1, 3'd1}));
        chk("last_z4", int'(log_q[23].z[4]), 'h46);
        chk("last_xy", int'({log_q[23].x, log_q[23].y}), int'({3'd6, 3'd4}));
        chk("last_fd", int'(log_q[23].fd), 1);
      end
      if (i == 2 && log_q.size() == 31) begin
        chk("resync_z0", int'(log_q[7].z[0]), 'h80);
        chk("resync_xy", int'({log_q[7].x, log_q[7].y}), int'({3'd1, 3'd1}));
      end
      if (i == 3 && log_q.size() == 48) begin
        chk("f2_z0", int'(log_q[24].z[0]), 'h80);
        chk("f2_z8", int'(log_q[24].z[8]), 'hA2);
      end
    end

    // Async reset between edges mid-stream
    clear_logs();
    send_frame(8'h00, 0, 3, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_win_valid", int'(win_valid), 0);
    chk("async_frame_done", int'(frame_done), 0);
    chk("async_xy", int'({win_x, win_y}), 0);
    chk("async_z", int'({z0, z1, z2, z3}) | int'({z4, z5, z6, z7}) | int'(z8), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_logs();
    send_frame(8'h00, 0, H, W);
    repeat (3) @(posedge clock);
    #1;
    chk("post_rst_pulses", n_pulse, 24);
    chk("post_rst_fd", n_fd, 1);
    chk("post_rst_drain", exp_q.size(), 0);

    // 3x3 frame: exactly one interior window
    for (int k = 0; k < 9; k++) begin
      b_pix   = 8'(k);
      b_sof   = (k == 0);
      b_valid = 1'b1;
      @(posedge clock);
      #1;
    end
    b_valid = 1'b0;
    b_sof   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("border_pulses", b_pulse, 1);
    chk("border_x", b_x, 1);
    chk("border_y", b_y, 1);
    chk("border_fd", b_fd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_window.md
Name: sobel_window

Overview:
- Generates the 3x3 pixel neighbourhood (z0..z8) that the Sobel edge stage consumes, from a raster-order 8-bit grayscale pixel stream.
- Holds two line buffers plus three 3-deep column shift registers.
- Emits one window per accepted pixel once the window is fully interior to the frame.
- Sits between the camera/ZBT pixel reader and the Sobel stage.

Parameters:
- WIDTH, 640, pixels per line (>=3)
- HEIGHT, 480, lines per frame (>=3)
- XW, 10, width of column counter / win_x
- YW, 9, width of row counter / win_y

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- pix_in  input  8  grayscale pixel
- pix_valid  input  1  pix_in accepted this cycle when high
- sof  input  1  start of frame; qualified by pix_valid, marks pixel (0,0)
- z0..z8  output  8 each  window, row-major: z0 z1 z2 top row (left..right), z3 z4 z5 middle row, z6 z7 z8 bottom row
- win_valid  output  1  one-cycle pulse, z0..z8/win_x/win_y valid
- win_x  output  XW  column of centre pixel (z4)
- win_y  output  YW  row of centre pixel (z4)
- frame_done  output  1  one-cycle pulse coincident with last window of a complete frame

Behaviour:
- Reset, asynchronous via reset_n low: z0..z8, win_valid, win_x, win_y, frame_done and the col/row counters all go to 0. Line buffer RAM is not cleared; its contents are gated out by the row rule below.
- Counters (col 0..WIDTH-1, row 0..HEIGHT-1) advance only on pix_valid:
  - col wraps to 0 and row increments.
  - At (WIDTH-1, HEIGHT-1) both wrap to 0.
- sof & pix_valid: the current pixel is taken as (0,0), so the next accepted pixel is (1,0). This resyncs regardless of counter state.
- Line buffers, on an accepted pixel at column c:
  - read lb1[c] (row-1) and lb2[c] (row-2);
  - write lb2[c] <= old lb1[c] and lb1[c] <= pix_in;
  - read-before-write in the same cycle.
- Window shift on an accepted pixel:
  - left column <= middle column;
  - middle column <= right column;
  - new right column (z2, z5, z8) <= (lb2[c], lb1[c], pix_in).
- Latency: window outputs register one cycle after the accepting edge.
- Validity:
  - win_valid = 1 on the cycle after accepting pixel (r,c) iff r>=2 and c>=2, with win_x = c-1 and win_y = r-1.
  - Windows never straddle a line wrap (c>=2 guarantees three same-row columns).
  - Per frame this gives (WIDTH-2)*(HEIGHT-2) pulses.
- pix_valid low: no shift and no counter change; z*, win_x, win_y hold their values, and win_valid = 0. There is no backpressure; the downstream stage accepts every pulse.
- frame_done is asserted with the window for pixel (WIDTH-1, HEIGHT-1), i.e. win_x = WIDTH-2, win_y = HEIGHT-2, but only if that frame started with sof or from reset with no mid-frame sof.
- sof mid-frame:
  - the aborted frame produces no frame_done;
  - win_valid is suppressed until the new frame reaches row 2, col 2;
  - stale line-buffer data is never exposed.
- Arithmetic: unsigned, with no saturation. The counter compare is done at full XW/YW width.

Test Plan:
- Reset: reset_n low mid-stream, asynchronously between edges → all outputs 0 before the next clock edge. After release, a full frame is reproduced exactly.
- Ramp, WIDTH=8, HEIGHT=6, pix = 16*row + col, pix_valid continuous:
  - first win_valid one cycle after pixel (2,2), with z0..z8 = 00,01,02,10,11,12,20,21,22 and win_x=1, win_y=1;
  - exactly 24 pulses total;
  - last pulse has z4 = 0x46, x=6, y=4, with frame_done=1.
- Same ramp with pix_valid toggling 1,0,1,0 → identical window sequence; outputs hold and win_valid=0 on idle cycles.
- Ramp with sof re-asserted at pixel (3,3) →
  - no frame_done for the aborted frame;
  - next win_valid only after new-frame pixel (2,2), with z values from the new frame only.
- Two back-to-back frames, second frame = ramp + 0x80 →
  - frame_done once per frame;
  - first window of frame 2 has z0=0x80 and z8=0xA2, with no mixing of frame-1 data.
- Border check, WIDTH=3, HEIGHT=3 → exactly one win_valid, with x=1, y=1 and frame_done=1.
